matrix_chunk_loader: RTL and testbench



---
 rtl/matrix_chunk_loader.sv | 172 +++++++++++++++++
 tb/tb_matrix_chunk_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_chunk_loader.sv
// Matrix SRAM responder: preloaded Q2.14 weight store that returns BANDWIDTH
// consecutive words per request. Define MATRIX_LOADER_PERF_EN for perf counters.
module matrix_chunk_loader #(
    parameter int MAX_ROWS   = 64,
    parameter int MAX_COLS   = 64,
    parameter int BANDWIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    localparam int DEPTH     = MAX_ROWS * MAX_COLS,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_we,
    input  logic [AW-1:0]                 load_addr,
    input  logic [DATA_WIDTH-1:0]         load_data,
    output logic                          load_err,
    input  logic                          matrix_enable,
    input  logic [AW-1:0]                 matrix_addr,
    output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
    output logic                          matrix_ready,
    output logic                          busy
`ifdef MATRIX_LOADER_PERF_EN
    ,
    output logic [31:0]                   perf_chunks,
    output logic [31:0]                   perf_aborts
`endif
);

    localparam int CW = $clog2(BANDWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BANDWIDTH);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [AW-1:0]         base_r;
    logic [CW-1:0]         cnt_r;
    logic                  rd_oor_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW:0]           issue_addr_s;
    logic                  oor_s;
    logic                  issue_s;
    logic                  capture_s;
    logic                  ram_we_s;
    logic                  ram_re_s;
    logic [AW-1:0]         ram_addr_s;

    // Issue/capture pipeline control: cnt_r counts issued reads, capture trails by one.
    always_comb begin
        issue_addr_s = {1'b0, base_r} + {{(AW+1-CW){1'b0}}, cnt_r};
        oor_s        = (issue_addr_s >= DEPTH_X);
        issue_s      = (state_r == S_FETCH) && matrix_enable && (cnt_r != LAST);
        capture_s    = (state_r == S_FETCH) && matrix_enable && (cnt_r != {CW{1'b0}});
        ram_we_s     = (state_r == S_IDLE) && load_we;
        ram_re_s     = issue_s && !oor_s;
        if (ram_we_s) begin
            ram_addr_s = load_addr;
        end else begin
            ram_addr_s = issue_addr_s[AW-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (matrix_enable) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (!matrix_enable) begin
                    next_state_s = S_IDLE;
                end else if (cnt_r == LAST) begin
                    next_state_s = S_READY;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_READY: begin
                if (!matrix_enable) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_READY;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Weight storage: single port, one-cycle read latency, never reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[ram_addr_s] <= load_data;
        end
        if (ram_re_s) begin
            rd_data_r <= mem[ram_addr_s];
        end
    end

    // Request datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r       <= {AW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            rd_oor_r     <= 1'b0;
            matrix_data  <= {(DATA_WIDTH*BANDWIDTH){1'b0}};
            matrix_ready <= 1'b0;
            busy         <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            matrix_ready <= (next_state_s == S_READY);
            busy         <= (next_state_s != S_IDLE);
            load_err     <= load_we && (state_r != S_IDLE);
            if ((state_r == S_IDLE) && matrix_enable) begin
                base_r <= matrix_addr;
                cnt_r  <= {CW{1'b0}};
            end else if (issue_s) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (issue_s) begin
                rd_oor_r <= oor_s;
            end
            // Lane cnt_r-1 receives the word whose read was issued last cycle.
            for (int i = 0; i < BANDWIDTH; i++) begin
                if (capture_s && (cnt_r == CW'(i + 1))) begin
                    matrix_data[i*DATA_WIDTH +: DATA_WIDTH] <=
                        rd_oor_r ? {DATA_WIDTH{1'b0}} : rd_data_r;
                end
            end
        end
    end

`ifdef MATRIX_LOADER_PERF_EN
    // Saturating completion and abort counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_chunks <= 32'd0;
            perf_aborts <= 32'd0;
        end else begin
            if ((state_r == S_FETCH) && (next_state_s == S_READY) &&
                (perf_chunks != 32'hFFFF_FFFF)) begin
                perf_chunks <= perf_chunks + 32'd1;
            end
            if ((state_r == S_FETCH) && (next_state_s == S_IDLE) &&
                (perf_aborts != 32'hFFFF_FFFF)) begin
                perf_aborts <= perf_aborts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_chunk_loader.sv
// Bench for matrix_chunk_loader: requests push expected chunks/latency into a
// queue; a negedge monitor pops on each rising matrix_ready and compares.
module tb_matrix_chunk_loader;

    localparam int BW = 16;
    localparam int DW = 16;
    localparam int DEPTH = 4096;
    localparam int AW = 12;
    localparam int CHW = BW * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_we = 1'b0;
    logic [AW-1:0]   load_addr = '0;
    logic [DW-1:0]   load_data = '0;
    logic            load_err;
    logic            matrix_enable = 1'b0;
    logic [AW-1:0]   matrix_addr = '0;
    logic [CHW-1:0]  matrix_data;
    logic            matrix_ready;
    logic            busy;
`ifdef MATRIX_LOADER_PERF_EN
    logic [31:0]     perf_chunks;
    logic [31:0]     perf_aborts;
`endif

    matrix_chunk_loader dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .load_err(load_err),
        .matrix_enable(matrix_enable), .matrix_addr(matrix_addr),
        .matrix_data(matrix_data), .matrix_ready(matrix_ready), .busy(busy)
`ifdef MATRIX_LOADER_PERF_EN
        , .perf_chunks(perf_chunks), .perf_aborts(perf_aborts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CHW-1:0] d;
        int             t;
    } exp_t;

    exp_t           sb[$];
    logic [DW-1:0]  mdl [DEPTH];
    logic [CHW-1:0] last_exp;
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_err = 0;
    logic           ready_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [CHW-1:0] act, input logic [CHW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected chunk from the bench's own record of what it preloaded.
    function automatic logic [CHW-1:0] chunk(input int base);
        logic [CHW-1:0] c;
        c = '0;
        for (int k = 0; k < BW; k++) begin
            if (base + k < DEPTH) c[k*DW +: DW] = mdl[base + k];
        end
        return c;
    endfunction

    // Monitor: each rising matrix_ready must match the oldest outstanding request.
    always @(negedge clk) begin
        if (matrix_ready && !ready_prev) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ready: got ready=1 expected no outstanding request");
            end else begin
                e = sb.pop_front();
                check("chunk_data", matrix_data, e.d);
                check("latency", CHW'(cyc - e.t), CHW'(18));
            end
        end
        ready_prev = matrix_ready;
    end

    task automatic start_req(input int base);
        exp_t e;
        e.d = chunk(base);
        e.t = cyc;
        last_exp = e.d;
        sb.push_back(e);
        matrix_addr = AW'(base);
        matrix_enable = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!matrix_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!matrix_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 40 cycles");
        end
    endtask

    task automatic end_req();
        matrix_enable = 1'b0;
        @(negedge clk);
        check("ready_drop", CHW'(matrix_ready), CHW'(0));
        check("busy_after_drop", CHW'(busy), CHW'(0));
    endtask

    initial begin
        logic [CHW-1:0] partial;

        repeat (3) @(negedge clk);
        check("rst_ready", CHW'(matrix_ready), CHW'(0));
        check("rst_data", matrix_data, CHW'(0));
        check("rst_busy", CHW'(busy), CHW'(0));
        check("rst_load_err", CHW'(load_err), CHW'(0));
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1;
            load_addr = AW'(i);
            load_data = DW'(i);
            mdl[i] = DW'(i);
            @(negedge clk);
        end
        load_we = 1'b0;
        check("no_load_err_idle", CHW'(load_err), CHW'(0));

        // Basic chunk at 0x010, then hold check after enable drops.
        start_req(16'h0010);
        @(negedge clk);
        wait_ready();
        check("busy_in_ready", CHW'(busy), CHW'(1));
        end_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("data_hold", matrix_data, last_exp);
        end

        // Chunk straddling the end of storage.
        start_req(4088);
        @(negedge clk);
        wait_ready();
        check("tail_lanes", matrix_data,
              {128'd0, 16'd4095, 16'd4094, 16'd4093, 16'd4092,
               16'd4091, 16'd4090, 16'd4089, 16'd4088});
        end_req();

        // Abort at 0x100 after 5 cycles: lanes 0..2 captured, the rest keep old values.
        matrix_addr = 12'h100;
        matrix_enable = 1'b1;
        repeat (5) @(negedge clk);
        matrix_enable = 1'b0;
        @(negedge clk);
        check("abort_busy", CHW'(busy), CHW'(0));
        check("abort_ready", CHW'(matrix_ready), CHW'(0));
        partial = last_exp;
        partial[0*DW +: DW] = 16'h0100;
        partial[1*DW +: DW] = 16'h0101;
        partial[2*DW +: DW] = 16'h0102;
        check("abort_partial", matrix_data, partial);
`ifdef MATRIX_LOADER_PERF_EN
        check("perf_aborts", CHW'(perf_aborts), CHW'(1));
        check("perf_chunks", CHW'(perf_chunks), CHW'(2));
`endif

        // Preload collision during a fetch is dropped with one load_err pulse.
        start_req(16'h0030);
        repeat (3) @(negedge clk);
        load_we = 1'b1;
        load_addr = 12'h020;
        load_data = 16'hBEEF;
        @(negedge clk);
        load_we = 1'b0;
        check("load_err_pulse", CHW'(load_err), CHW'(1));
        @(negedge clk);
        check("load_err_clear", CHW'(load_err), CHW'(0));
        wait_ready();
        end_req();
        start_req(16'h0020);
        @(negedge clk);
        wait_ready();
        check("collision_lane0", CHW'(matrix_data[DW-1:0]), CHW'(16'h0020));
        end_req();

        // Write and request in the same idle cycle: fetch sees the new word.
        load_we = 1'b1;
        load_addr = 12'h040;
        load_data = 16'h1234;
        mdl[16'h040] = 16'h1234;
        start_req(16'h0040);
        @(negedge clk);
        load_we = 1'b0;
        wait_ready();
        check("same_cycle_lane0", CHW'(matrix_data[DW-1:0]), CHW'(16'h1234));
        end_req();

        // Reset while in S_READY.
        start_req(16'h0200);
        @(negedge clk);
        wait_ready();
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_mid", CHW'(matrix_ready), CHW'(0));
        check("rst_data_mid", matrix_data, CHW'(0));
        check("rst_busy_mid", CHW'(busy), CHW'(0));
`ifdef MATRIX_LOADER_PERF_EN
        check("perf_rst", CHW'(perf_chunks), CHW'(0));
`endif
        rst = 1'b0;
        matrix_enable = 1'b0;
        @(negedge clk);
        start_req(16'h07F0);
        @(negedge clk);
        wait_ready();
        end_req();

        repeat (2) @(negedge clk);
        check("scoreboard_empty", CHW'(sb.size()), CHW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
